// File: rtl/eq_compare_seq_pkg.sv
// Shared types and constants for the eq_compare_seq sequencer.
package eq_cmp_pkg;

    // Width of one comparison slice handled by the shared equality cell.
    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/eq_compare_seq_if.sv
// Host-side start/done handshake and operand/result bundle for eq_compare_seq.
interface eq_compare_seq_if #(
    parameter int WIDTH = 8
);
    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = $clog2(NSLICE + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [CW-1:0]    slices;

    // Host drives the request and operands, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, equal, slices
    );

    // Sequencer consumes the request and operands, drives status and result.
    modport slave (
        input  start, a, b,
        output busy, done, equal, slices
    );

endinterface

// File: rtl/eq_compare_seq_cmp2_eq.sv
// Combinational 2-bit equality cell shared by every slice of an operation.
module cmp2_eq
    import eq_cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               f
);

    // Both bit pairs must match for the slice to count as equal.
    always_comb begin
        f = ~(a[1] ^ b[1]) & ~(a[0] ^ b[0]);
    end

endmodule

// File: rtl/eq_compare_seq.sv
// Sequenced WIDTH-bit equality check on one shared 2-bit cell, LSB slice first.
// Optional build macro: EARLY_EXIT_EN -- stop at the first mismatching slice
// instead of always walking all NSLICE slices.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched when start is accepted
// RUN   | one slice compared per clock from the shift-register LSBs
// DONE  | one-cycle done pulse; equal/slices already hold the result
module eq_compare_seq
    import eq_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    eq_compare_seq_if.slave bus
);

    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = $clog2(NSLICE + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_acc_q, eq_acc_d;
    logic             equal_q, equal_d;
    logic [CW-1:0]    slices_q, slices_d;

    logic             f;
    logic             run_eq;
    logic [CW-1:0]    run_cnt;
    logic             last_slice;

    cmp2_eq u_cmp2_eq (
        .a (sa_q[SLICE_W-1:0]),
        .b (sb_q[SLICE_W-1:0]),
        .f (f)
    );

    // Per-slice step: accumulated equality, slice count, and whether this slice ends the run.
    always_comb begin
        run_eq  = eq_acc_q & f;
        run_cnt = cnt_q + CW'(1);
`ifdef EARLY_EXIT_EN
        last_slice = (cnt_q == CW'(NSLICE - 1)) || !f;
`else
        last_slice = (cnt_q == CW'(NSLICE - 1));
`endif
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. The result registers are loaded on the RUN->DONE edge
    // so equal/slices are already valid while done is high.
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        eq_acc_d = eq_acc_q;
        equal_d  = equal_q;
        slices_d = slices_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d     = bus.a;
                    sb_d     = bus.b;
                    cnt_d    = '0;
                    eq_acc_d = 1'b1;
                    equal_d  = 1'b0;
                    slices_d = '0;
                end
            end
            RUN: begin
                sa_d     = sa_q >> SLICE_W;
                sb_d     = sb_q >> SLICE_W;
                cnt_d    = run_cnt;
                eq_acc_d = run_eq;
                if (last_slice) begin
                    equal_d  = run_eq;
                    slices_d = run_cnt;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            eq_acc_q <= 1'b0;
            equal_q  <= 1'b0;
            slices_q <= '0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            eq_acc_q <= eq_acc_d;
            equal_q  <= equal_d;
            slices_q <= slices_d;
        end
    end

    // Status decoded from the registered state; results straight from their flops.
    always_comb begin
        bus.busy   = (state_q == RUN);
        bus.done   = (state_q == DONE);
        bus.equal  = equal_q;
        bus.slices = slices_q;
    end

endmodule

// File: tb/tb_eq_compare_seq.sv
// Self-checking bench for eq_compare_seq: WIDTH=8 and WIDTH=2 instances.
// Honours EARLY_EXIT_EN in its expectations.
module tb_eq_compare_seq;

    localparam int NS = 4;

`ifdef EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    eq_compare_seq_if #(.WIDTH(8)) bus8 ();
    eq_compare_seq_if #(.WIDTH(2)) bus2 ();

    eq_compare_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    eq_compare_seq #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         eq;
        int         sl;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: slices = position of first differing 2-bit slice + 1 with early exit, else all.
    function automatic int model_slices(input logic [7:0] a, input logic [7:0] b);
        if (EARLY) begin
            for (int i = 0; i < NS; i++) begin
                if (((a >> (2 * i)) & 8'd3) != ((b >> (2 * i)) & 8'd3)) return i + 1;
            end
        end
        return NS;
    endfunction

    function automatic int model_eq(input logic [7:0] a, input logic [7:0] b);
        return (a == b) ? 1 : 0;
    endfunction

    // One operation on the 8-bit instance; operands are scrambled right after acceptance.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input int exp_eq, input int exp_sl, input string tag);
        int k;
        int busy_n;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        check({tag, "_accept_clears_equal"}, int'(bus8.equal), 0);
        check({tag, "_accept_clears_slices"}, int'(bus8.slices), 0);
        k      = 0;
        busy_n = 0;
        while (!bus8.done && k < 20) begin
            if (bus8.busy) busy_n++;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, exp_sl);
        check({tag, "_busy_cycles"}, busy_n, exp_sl);
        check({tag, "_equal"}, int'(bus8.equal), exp_eq);
        check({tag, "_slices"}, int'(bus8.slices), exp_sl);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, int'(bus8.done), 0);
    endtask

    task automatic run_op2(input logic [1:0] a, input logic [1:0] b,
                           input int exp_eq, input string tag);
        int k;
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.a     = a;
        bus2.b     = b;
        @(negedge clk);
        bus2.start = 1'b0;
        k = 0;
        while (!bus2.done && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 1);
        check({tag, "_equal"}, int'(bus2.equal), exp_eq);
        check({tag, "_slices"}, int'(bus2.slices), 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, int'(bus2.done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] av[40];
        logic [7:0] bv[40];
        logic [7:0] ra, rb;
        int next_acc, done_edge, exp_eq, exp_sl, L, done_seen;

        vecs[0] = '{8'hA5, 8'hA5, 1, 4};
        vecs[1] = '{8'hA5, 8'hA4, 0, EARLY ? 1 : 4};
        vecs[2] = '{8'h00, 8'hC0, 0, 4};
        vecs[3] = '{8'h3C, 8'h3C, 1, 4};
        vecs[4] = '{8'hFF, 8'h7F, 0, 4};
        vecs[5] = '{8'h12, 8'h1A, 0, EARLY ? 2 : 4};

        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus2.start = 1'b0;
        bus2.a     = '0;
        bus2.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(bus8.busy), 0);
        check("reset_done", int'(bus8.done), 0);
        check("reset_equal", int'(bus8.equal), 0);
        check("reset_slices", int'(bus8.slices), 0);
        check("reset_done_w2", int'(bus2.done), 0);
        rst = 1'b0;

        // Fixed vectors, including the LSB-slice and MSB-slice mismatch cases.
        for (int i = 0; i < 6; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].sl, $sformatf("vec%0d", i));
        end

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = 8'($urandom);
                default: rb = ra ^ (8'd3 << (2 * $urandom_range(0, 3)));
            endcase
            run_op8(ra, rb, model_eq(ra, rb), model_slices(ra, rb), $sformatf("rnd%0d", i));
        end

        // start held high while operands change every cycle.
        for (int e = 0; e < 40; e++) begin
            av[e] = 8'($urandom);
            bv[e] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : av[e];
        end
        next_acc  = 0;
        done_edge = -1;
        exp_eq    = 0;
        exp_sl    = 0;
        for (int e = 0; e < 40; e++) begin
            bus8.start = 1'b1;
            bus8.a     = av[e];
            bus8.b     = bv[e];
            @(negedge clk);
            if (e == next_acc) begin
                L         = model_slices(av[e], bv[e]);
                exp_eq    = model_eq(av[e], bv[e]);
                exp_sl    = L;
                done_edge = e + L;
                next_acc  = e + L + 2;
            end
            check($sformatf("hold_done_e%0d", e), int'(bus8.done), (e == done_edge) ? 1 : 0);
            if (e == done_edge) begin
                check($sformatf("hold_equal_e%0d", e), int'(bus8.equal), exp_eq);
                check($sformatf("hold_slices_e%0d", e), int'(bus8.slices), exp_sl);
            end
        end
        bus8.start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during the second RUN cycle aborts without a done pulse.
        run_op8(8'h5A, 8'h5A, 1, 4, "pre_abort");
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hA5;
        bus8.b     = 8'hA5;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(bus8.busy), 0);
        check("abort_done", int'(bus8.done), 0);
        check("abort_equal", int'(bus8.equal), 0);
        check("abort_slices", int'(bus8.slices), 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus8.done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_op8(8'h3C, 8'h3C, 1, 4, "post_abort");

        // Single-slice instance.
        run_op2(2'b10, 2'b10, 1, "w2_eq");
        run_op2(2'b10, 2'b11, 0, "w2_ne");
        run_op2(2'b00, 2'b00, 1, "w2_zero");
        run_op2(2'b01, 2'b11, 0, "w2_msb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
